vga_ctrl: RTL and testbench
===========================

VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 SHALL have parameters: H_SYNC 96; H_BACK 40; H_LEFT 8; H_VALID 640; H_RIGHT 8; H_FRONT 8; H_TOTAL 800 (sum of the H terms). All counts are in vga_clk cycles.
REQ-002 SHALL have parameters: V_SYNC 2; V_BACK 25; V_TOP 8; V_VALID 480; V_BOTTOM 8; V_FRONT 2; V_TOTAL 525 (sum of the V terms). All counts are in lines.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have these ports:
- vga_clk  in  1  sole clock, 25 MHz pixel clock.
- sys_rst  in  1  asynchronous, active-high reset.
- pix_data  in  16  RGB565 pixel from the picture stage, registered there one cycle after pix_x/pix_y.
- pix_x  out  10  requested column; 10'h3ff when no request.
- pix_y  out  10  requested row; 10'h3ff when no request.
- hsync  out  1  horizontal sync, high during the sync pulse.
- vsync  out  1  vertical sync, high during the sync pulse.
- rgb_valid  out  1  high while an active pixel is on rgb.
- rgb  out  16  pixel to the DAC; 16'h0000 outside the active area.
- frame_start  out  1  one-cycle pulse at the start of each new frame.

Function
REQ-005 SHALL keep cnt_h (10 bit), running 0..H_TOTAL-1 and incrementing every cycle; at H_TOTAL-1 it wraps to 0.
REQ-006 SHALL keep cnt_v (10 bit), which advances only in cycles where cnt_h==H_TOTAL-1, running 0..V_TOTAL-1; wraps to 0 when cnt_v==V_TOTAL-1 at the same time as cnt_h==H_TOTAL-1.
REQ-007 SHALL drive hsync=1 iff cnt_h<H_SYNC, and vsync=1 iff cnt_v<V_SYNC; both are combinational decodes of the counters.
REQ-008 SHALL define HS=H_SYNC+H_BACK+H_LEFT (144) and VS=V_SYNC+V_BACK+V_TOP (35).
REQ-009 SHALL assert rgb_valid iff HS<=cnt_h<HS+H_VALID and VS<=cnt_v<VS+V_VALID.
REQ-010 SHALL assert the internal pix_req iff HS-1<=cnt_h<HS+H_VALID-1 and VS<=cnt_v<VS+V_VALID; pix_req leads rgb_valid by exactly one cycle to absorb the picture stage's one-cycle latency.
REQ-011 SHALL drive pix_x=cnt_h-(HS-1) and pix_y=cnt_v-VS when pix_req=1, and 10'h3ff on both otherwise; the values are truncated to 10 bits, with no overflow possible in range.
REQ-012 SHALL drive rgb=pix_data when rgb_valid=1, and 16'h0000 otherwise; there is zero added latency from pix_data to rgb.
REQ-013 SHALL register frame_start, pulsing it for exactly one cycle in the cycle after cnt_h==H_TOTAL-1 and cnt_v==V_TOTAL-1 (counters then at 0,0); it is never asserted in the first frame after reset.
REQ-014 SHALL request each active pixel exactly once per frame, in raster order (x fastest); per frame this is 640 per line, 480 lines and 307200 total.
REQ-015 SHALL, at line wrap (cnt_h 799->0), leave pix_x at 10'h3ff and keep hsync asserted from cnt_h=0 of the new line.
REQ-016 SHALL, at frame wrap, update cnt_v and cnt_h in the same edge, with vsync rising in the same cycle as hsync and frame_start.

Reset
REQ-017 SHALL, while sys_rst=1 and asynchronously on assertion, hold cnt_h=0, cnt_v=0 and frame_start=0.
REQ-018 SHALL hold these output reset values: hsync=1, vsync=1, pix_x=10'h3ff, pix_y=10'h3ff, rgb_valid=0, rgb=16'h0000, frame_start=0.
REQ-019 SHALL, on reset assertion mid-line or mid-frame, abandon the current frame; after release, the first rising edge advances cnt_h to 1 and timing restarts from the frame origin.

Verification
REQ-020 SHALL pass the sync-period scenario: release reset, measure sync -> hsync high 96 cycles, low 704 cycles, period 800; vsync high 1600 cycles, period 420000 cycles.
REQ-021 SHALL pass the first-pixel scenario: cnt_v=35, cnt_h=143 -> pix_x=0 and pix_y=0; at the next edge rgb_valid=1 and rgb equals pix_data (drive 16'hF800 -> rgb=16'hF800).
REQ-022 SHALL pass the last-pixel scenario: cnt_v=514, cnt_h=782 -> pix_x=639 and pix_y=479; at cnt_h=783, pix_x=pix_y=10'h3ff; rgb_valid falls at cnt_h=784.
REQ-023 SHALL pass the counting scenario: connect the picture stage, run one full frame, count rgb_valid cycles -> 307200; rgb is 16'h0000 in every cycle with rgb_valid=0.
REQ-024 SHALL pass the mid-line reset scenario: assert sys_rst at cnt_h=400, cnt_v=100 -> outputs reach REQ-018 values without waiting for an edge; after release, hsync is high for exactly 96 cycles from cnt_h=0.
REQ-025 SHALL pass the frame_start scenario: run 3 frames after reset -> frame_start is 0 in the first frame, then exactly one single-cycle pulse every 420000 cycles, coinciding with the rising edge of vsync.

Source files
------------

// File: rtl/vga_ctrl_if.sv
// Pixel-side bundle of the VGA timing controller: the pixel request going out to
// the picture stage, its returned pixel, and the sync/colour signals for the DAC.
interface vga_ctrl_if;
  logic [15:0] pix_data;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        hsync;
  logic        vsync;
  logic        rgb_valid;
  logic [15:0] rgb;
  logic        frame_start;

  modport master (
    input  pix_data,
    output pix_x, pix_y, hsync, vsync, rgb_valid, rgb, frame_start
  );

  modport slave (
    output pix_data,
    input  pix_x, pix_y, hsync, vsync, rgb_valid, rgb, frame_start
  );
endinterface

// File: rtl/vga_ctrl.sv
// Raster timing generator (640x480@60 by default). Each pixel is requested one cycle
// ahead of display so that a registered picture stage lines up with rgb_valid.
module vga_ctrl #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 40,
  parameter int unsigned H_LEFT   = 8,
  parameter int unsigned H_VALID  = 640,
  parameter int unsigned H_RIGHT  = 8,
  parameter int unsigned H_FRONT  = 8,
  parameter int unsigned H_TOTAL  = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 25,
  parameter int unsigned V_TOP    = 8,
  parameter int unsigned V_VALID  = 480,
  parameter int unsigned V_BOTTOM = 8,
  parameter int unsigned V_FRONT  = 2,
  parameter int unsigned V_TOTAL  = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  vga_ctrl_if.master vga
);

  localparam int unsigned HS = H_SYNC + H_BACK + H_LEFT;
  localparam int unsigned VS = V_SYNC + V_BACK + V_TOP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_BEG  = 10'(HS);
  localparam logic [9:0] H_ACT_END  = 10'(HS + H_VALID);
  localparam logic [9:0] H_REQ_BEG  = 10'(HS - 1);
  localparam logic [9:0] H_REQ_END  = 10'(HS + H_VALID - 1);
  localparam logic [9:0] V_ACT_BEG  = 10'(VS);
  localparam logic [9:0] V_ACT_END  = 10'(VS + V_VALID);
  localparam logic [9:0] NO_REQ     = 10'h3ff;

  logic [9:0] cnt_h_q, cnt_h_d;
  logic [9:0] cnt_v_q, cnt_v_d;
  logic       frame_start_q, frame_start_d;
  logic       h_last, v_last;
  logic       v_active, pix_req, act;

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no path infers a latch.
    h_last        = (cnt_h_q == H_LAST);
    v_last        = (cnt_v_q == V_LAST);
    cnt_h_d       = cnt_h_q + 10'd1;
    cnt_v_d       = cnt_v_q;
    frame_start_d = 1'b0;
    if (h_last) begin
      cnt_h_d       = '0;
      cnt_v_d       = v_last ? '0 : cnt_v_q + 10'd1;
      frame_start_d = v_last;
    end
  end

  // NOTE: state uses non-blocking assignments and an async reset, so reset lands at the frame origin immediately.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_h_q       <= '0;
      cnt_v_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_h_q       <= cnt_h_d;
      cnt_v_q       <= cnt_v_d;
      frame_start_q <= frame_start_d;
    end
  end

  // The request window sits one column left of the display window.
  always_comb begin
    v_active = (cnt_v_q >= V_ACT_BEG) && (cnt_v_q < V_ACT_END);
    pix_req  = v_active && (cnt_h_q >= H_REQ_BEG) && (cnt_h_q < H_REQ_END);
    act      = v_active && (cnt_h_q >= H_ACT_BEG) && (cnt_h_q < H_ACT_END);
  end

  assign vga.hsync       = (cnt_h_q < H_SYNC_END);
  assign vga.vsync       = (cnt_v_q < V_SYNC_END);
  assign vga.pix_x       = pix_req ? (cnt_h_q - H_REQ_BEG) : NO_REQ;
  assign vga.pix_y       = pix_req ? (cnt_v_q - V_ACT_BEG) : NO_REQ;
  assign vga.rgb_valid   = act;
  assign vga.rgb         = act ? vga.pix_data : 16'h0000;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: a reduced-geometry instance (random image, random resets, pixel
// scoreboard) and a default 640x480 instance checked through its first active line.
`timescale 1ns/1ps
module tb_vga_ctrl;

  localparam int SH_SYNC = 3, SH_BACK = 2, SH_LEFT = 1, SH_VALID = 6, SH_RIGHT = 1, SH_FRONT = 2;
  localparam int SV_SYNC = 2, SV_BACK = 1, SV_TOP = 1, SV_VALID = 4, SV_BOTTOM = 1, SV_FRONT = 1;
  localparam int S_HS0   = SH_SYNC + SH_BACK + SH_LEFT;
  localparam int S_HT    = S_HS0 + SH_VALID + SH_RIGHT + SH_FRONT;
  localparam int S_VS0   = SV_SYNC + SV_BACK + SV_TOP;
  localparam int S_VT    = S_VS0 + SV_VALID + SV_BOTTOM + SV_FRONT;
  localparam int S_FRAME = S_HT * S_VT;

  localparam int D_HS0   = 96 + 40 + 8;
  localparam int D_HT    = D_HS0 + 640 + 8 + 8;
  localparam int D_VS0   = 2 + 25 + 8;
  localparam int D_VT    = D_VS0 + 480 + 8 + 2;
  localparam int D_LIMIT = 29000;  // past the whole first active line (row 35)

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       valid;
    logic       fs;
    logic [9:0] px;
    logic [9:0] py;
    int         x;
    int         y;
  } exp_t;

  logic clk = 1'b0;
  logic rst_s, rst_d;
  int   t_s = 0, t_d = 0;
  int   n_cmp = 0, n_bad = 0;
  logic [15:0] img [SV_VALID][SH_VALID];
  logic [15:0] sb_q [$];
  int   pushed_frame = -1;

  vga_ctrl_if vif_s ();
  vga_ctrl_if vif_d ();

  vga_ctrl #(
    .H_SYNC(SH_SYNC), .H_BACK(SH_BACK), .H_LEFT(SH_LEFT), .H_VALID(SH_VALID),
    .H_RIGHT(SH_RIGHT), .H_FRONT(SH_FRONT),
    .V_SYNC(SV_SYNC), .V_BACK(SV_BACK), .V_TOP(SV_TOP), .V_VALID(SV_VALID),
    .V_BOTTOM(SV_BOTTOM), .V_FRONT(SV_FRONT)
  ) u_small (
    .vga_clk(clk),
    .sys_rst(rst_s),
    .vga    (vif_s)
  );

  vga_ctrl u_dflt (
    .vga_clk(clk),
    .sys_rst(rst_d),
    .vga    (vif_d)
  );

  always #5 clk = ~clk;

  // Reference: position in the raster follows purely from edges since reset release.
  function automatic exp_t model(int t, int h_sync, int hs0, int h_valid, int h_total,
                                 int v_sync, int vs0, int v_valid, int v_total);
    exp_t e;
    int   p, h, v;
    bit   v_in;
    p       = t % (h_total * v_total);
    h       = p % h_total;
    v       = p / h_total;
    v_in    = (v >= vs0) && (v < vs0 + v_valid);
    e.hsync = (h < h_sync);
    e.vsync = (v < v_sync);
    e.valid = v_in && (h >= hs0) && (h < hs0 + h_valid);
    e.fs    = (t >= h_total * v_total) && (p == 0);
    e.x     = h - hs0;
    e.y     = v - vs0;
    // The coordinate requested now is the pixel that will be on screen next cycle.
    if (v_in && (h + 1 >= hs0) && (h + 1 < hs0 + h_valid)) begin
      e.px = 10'(h + 1 - hs0);
      e.py = 10'(v - vs0);
    end else begin
      e.px = 10'h3ff;
      e.py = 10'h3ff;
    end
    return e;
  endfunction

  function automatic logic [15:0] pic(int x, int y);
    return 16'hF800 ^ {x[5:0], y[9:0]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst_s)
    if (rst_s) t_s <= 0;
    else       t_s <= t_s + 1;

  always @(posedge clk or posedge rst_d)
    if (rst_d) t_d <= 0;
    else       t_d <= t_d + 1;

  // Registered picture stages; junk is returned for idle requests so rgb masking is exercised.
  always @(posedge clk) begin
    if (vif_s.pix_x < SH_VALID && vif_s.pix_y < SV_VALID)
      vif_s.pix_data <= img[vif_s.pix_y][vif_s.pix_x];
    else
      vif_s.pix_data <= 16'($urandom);
    if (vif_d.pix_x != 10'h3ff)
      vif_d.pix_data <= pic(32'(vif_d.pix_x), 32'(vif_d.pix_y));
    else
      vif_d.pix_data <= 16'($urandom);
  end

  // Small-instance monitor: timing against the model, pixels against the scoreboard.
  always @(negedge clk) begin
    exp_t        e;
    int          fi;
    logic [15:0] want;
    e = model(t_s, SH_SYNC, S_HS0, SH_VALID, S_HT, SV_SYNC, S_VS0, SV_VALID, S_VT);
    if (rst_s) begin
      sb_q.delete();
      pushed_frame = -1;
    end else begin
      fi = t_s / S_FRAME;
      if (fi != pushed_frame) begin
        if (pushed_frame >= 0) check("s_frame_drained", 32'(sb_q.size()), 32'd0);
        for (int y = 0; y < SV_VALID; y++)
          for (int x = 0; x < SH_VALID; x++)
            sb_q.push_back(img[y][x]);
        pushed_frame = fi;
      end
    end
    check("s_hsync",       32'(vif_s.hsync),       32'(e.hsync));
    check("s_vsync",       32'(vif_s.vsync),       32'(e.vsync));
    check("s_rgb_valid",   32'(vif_s.rgb_valid),   32'(e.valid));
    check("s_frame_start", 32'(vif_s.frame_start), 32'(e.fs));
    check("s_pix_x",       32'(vif_s.pix_x),       32'(e.px));
    check("s_pix_y",       32'(vif_s.pix_y),       32'(e.py));
    if (vif_s.rgb_valid === 1'b1) begin
      check("s_sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        want = sb_q.pop_front();
        check("s_rgb", 32'(vif_s.rgb), 32'(want));
      end
    end else begin
      check("s_rgb_blank", 32'(vif_s.rgb), 32'd0);
    end
  end

  // Default-geometry monitor over the first lines of the first frame.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] want;
    if (t_d < D_LIMIT) begin
      e    = model(t_d, 96, D_HS0, 640, D_HT, 2, D_VS0, 480, D_VT);
      want = e.valid ? pic(e.x, e.y) : 16'h0000;
      check("d_hsync",       32'(vif_d.hsync),       32'(e.hsync));
      check("d_vsync",       32'(vif_d.vsync),       32'(e.vsync));
      check("d_rgb_valid",   32'(vif_d.rgb_valid),   32'(e.valid));
      check("d_frame_start", 32'(vif_d.frame_start), 32'(e.fs));
      check("d_pix_x",       32'(vif_d.pix_x),       32'(e.px));
      check("d_pix_y",       32'(vif_d.pix_y),       32'(e.py));
      check("d_rgb",         32'(vif_d.rgb),         32'(want));
    end
  end

  initial begin
    for (int y = 0; y < SV_VALID; y++)
      for (int x = 0; x < SH_VALID; x++)
        img[y][x] = 16'($urandom);
    rst_s = 1'b1;
    rst_d = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst_s = 1'b0;
    rst_d = 1'b0;
    repeat (3 * S_FRAME) @(negedge clk);

    // Random mid-frame resets: outputs must collapse without waiting for a clock edge.
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(20, 2 * S_FRAME)) @(negedge clk);
      #2 rst_s = 1'b1;
      #1;
      check("rst_hsync",       32'(vif_s.hsync),       32'd1);
      check("rst_vsync",       32'(vif_s.vsync),       32'd1);
      check("rst_pix_x",       32'(vif_s.pix_x),       32'h3ff);
      check("rst_pix_y",       32'(vif_s.pix_y),       32'h3ff);
      check("rst_rgb_valid",   32'(vif_s.rgb_valid),   32'd0);
      check("rst_rgb",         32'(vif_s.rgb),         32'd0);
      check("rst_frame_start", 32'(vif_s.frame_start), 32'd0);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #2 rst_s = 1'b0;
    end
    repeat (3 * S_FRAME) @(negedge clk);

    for (int i = 0; i < D_LIMIT && t_d < D_LIMIT; i++) @(negedge clk);
    check("d_run_complete", 32'(t_d >= D_LIMIT), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
